// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1-to-4 demultiplexer.
//   NUM_OUT        number of output channels
//   WIDTH_DEFAULT  default data width
//   CNT_W_DEFAULT  default width of the optional per-channel delivery counters
//   chan_sel_t     2-bit destination channel select
//   sel_onehot()   decodes a channel select into a one-hot slot mask
package demux_pkg;

  localparam int unsigned NUM_OUT       = 4;
  localparam int unsigned WIDTH_DEFAULT = 8;
  localparam int unsigned CNT_W_DEFAULT = 16;

  typedef logic [1:0] chan_sel_t;

  function automatic logic [NUM_OUT-1:0] sel_onehot(input chan_sel_t sel);
    logic [NUM_OUT-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output register slice used for each channel of demux_registered.
// The valid flag is the slot state: low = EMPTY, high = FULL.
// Ports:
//   clk_i    clock, rising edge
//   rst_i    synchronous reset, active-high; empties the slot and zeroes its data
//   load_i   write d_i into the slot this cycle
//   d_i      data to load
//   ready_i  consumer takes the held word this cycle
//   q_o      held word (registered)
//   valid_o  slot holds a word
module demux_out_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] q_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_i) begin
      // A load wins over a same-cycle drain: the new word replaces the old
      // one and the slot stays full, giving one word per cycle throughput.
      data_d  = d_i;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q_o     = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/demux_registered.sv
// Registered 1-to-4 demultiplexer. One valid/ready input stream tagged with a
// destination select is steered into one of four independent one-entry output
// slots; each consumer drains its slot at its own pace. Input stalls only on
// the addressed slot (head-of-line blocking is intentional).
//
// Optional feature macro: DEMUX_REGISTERED_CNT_EN adds per-channel saturating
// delivery counters (parameter CNT_W, ports cnt_clr_i and cnt0_o..cnt3_o).
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous reset, active-high; drops all held words
//   in_valid_i     input word valid
//   in_ready_o     input can accept this cycle (combinational, addressed slot only)
//   sel_i          destination channel 0..3
//   in_i           input data
//   out0_o..out3_o channel data (registered)
//   out_valid_o    bit k: slot k holds a word
//   out_ready_i    bit k: consumer k takes the word this cycle
//   cnt_clr_i      [counters] synchronous clear of all counters
//   cnt0_o..cnt3_o [counters] words delivered on channel k, saturating
module demux_registered
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
`ifdef DEMUX_REGISTERED_CNT_EN
  ,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
`endif
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [1:0]         sel_i,
  input  logic [WIDTH-1:0]   in_i,
  output logic [WIDTH-1:0]   out0_o,
  output logic [WIDTH-1:0]   out1_o,
  output logic [WIDTH-1:0]   out2_o,
  output logic [WIDTH-1:0]   out3_o,
  output logic [NUM_OUT-1:0] out_valid_o,
  input  logic [NUM_OUT-1:0] out_ready_i
`ifdef DEMUX_REGISTERED_CNT_EN
  ,
  input  logic               cnt_clr_i,
  output logic [CNT_W-1:0]   cnt0_o,
  output logic [CNT_W-1:0]   cnt1_o,
  output logic [CNT_W-1:0]   cnt2_o,
  output logic [CNT_W-1:0]   cnt3_o
`endif
);

  chan_sel_t          sel;
  logic               accept;
  logic [NUM_OUT-1:0] load;
  logic [NUM_OUT-1:0] slot_valid;
  logic [WIDTH-1:0]   slot_data [NUM_OUT];

  assign sel = chan_sel_t'(sel_i);

  // The addressed slot can take a word if it is empty or is draining this cycle.
  assign in_ready_o = ~slot_valid[sel] | out_ready_i[sel];
  assign accept     = in_valid_i & in_ready_o;
  assign load       = accept ? sel_onehot(sel) : '0;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    demux_out_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (load[k]),
      .d_i     (in_i),
      .ready_i (out_ready_i[k]),
      .q_o     (slot_data[k]),
      .valid_o (slot_valid[k])
    );
  end

  assign out0_o      = slot_data[0];
  assign out1_o      = slot_data[1];
  assign out2_o      = slot_data[2];
  assign out3_o      = slot_data[3];
  assign out_valid_o = slot_valid;

`ifdef DEMUX_REGISTERED_CNT_EN
  logic [CNT_W-1:0]   cnt_q [NUM_OUT];
  logic [CNT_W-1:0]   cnt_d [NUM_OUT];
  logic [NUM_OUT-1:0] deliver;

  assign deliver = slot_valid & out_ready_i;

  always_comb begin
    for (int k = 0; k < NUM_OUT; k++) begin
      cnt_d[k] = cnt_q[k];
      if (cnt_clr_i) begin
        // Clear takes priority over a delivery in the same cycle.
        cnt_d[k] = '0;
      end else if (deliver[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NUM_OUT; k++) begin
      if (rst_i) begin
        cnt_q[k] <= '0;
      end else begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign cnt0_o = cnt_q[0];
  assign cnt1_o = cnt_q[1];
  assign cnt2_o = cnt_q[2];
  assign cnt3_o = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux_registered.sv
// Directed self-checking bench for demux_registered. Counter checks are built
// only when DEMUX_REGISTERED_CNT_EN is defined (the DUT then uses CNT_W=4).
module tb_demux_registered;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [1:0]       sel_i;
  logic [WIDTH-1:0] in_i;
  logic [WIDTH-1:0] out0_o, out1_o, out2_o, out3_o;
  logic [3:0]       out_valid_o;
  logic [3:0]       out_ready_i;
`ifdef DEMUX_REGISTERED_CNT_EN
  logic             cnt_clr_i;
  logic [CNT_W-1:0] cnt0_o, cnt1_o, cnt2_o, cnt3_o;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  demux_registered #(
    .WIDTH (WIDTH)
`ifdef DEMUX_REGISTERED_CNT_EN
    ,
    .CNT_W (CNT_W)
`endif
  ) u_dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .sel_i       (sel_i),
    .in_i        (in_i),
    .out0_o      (out0_o),
    .out1_o      (out1_o),
    .out2_o      (out2_o),
    .out3_o      (out3_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
`ifdef DEMUX_REGISTERED_CNT_EN
    ,
    .cnt_clr_i   (cnt_clr_i),
    .cnt0_o      (cnt0_o),
    .cnt1_o      (cnt1_o),
    .cnt2_o      (cnt2_o),
    .cnt3_o      (cnt3_o)
`endif
  );

  function automatic logic [WIDTH-1:0] out_k(input int k);
    case (k)
      0:       return out0_o;
      1:       return out1_o;
      2:       return out2_o;
      default: return out3_o;
    endcase
  endfunction

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i       = 1'b1;
    in_valid_i  = 1'b1;
    sel_i       = 2'd0;
    in_i        = 8'hFF;
    out_ready_i = 4'b0000;
    step();
    step();
    rst_i      = 1'b0;
    in_valid_i = 1'b0;
    #1;
    checks++;
    if (out_valid_o !== 4'b0000) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=0000", out_valid_o);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_k(k) !== 8'h00) begin
        failures++;
        $display("FAIL reset_out%0d got=%h exp=00", k, out_k(k));
      end
    end
    checks++;
    if (in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready_o);
    end
  endtask

  task automatic test_routing();
    logic [3:0] exp_v;
    logic [7:0] exp_d;
    out_ready_i = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      in_valid_i = 1'b1;
      sel_i      = 2'(k);
      in_i       = 8'hA0 + 8'(k);
      #1;
      checks++;
      if (in_ready_o !== 1'b1) begin
        failures++;
        $display("FAIL route_in_ready%0d got=%b exp=1", k, in_ready_o);
      end
      step();
      exp_v = 4'b0001 << k;
      exp_d = 8'hA0 + 8'(k);
      checks++;
      if (out_valid_o !== exp_v) begin
        failures++;
        $display("FAIL route_valid%0d got=%b exp=%b", k, out_valid_o, exp_v);
      end
      checks++;
      if (out_k(k) !== exp_d) begin
        failures++;
        $display("FAIL route_data%0d got=%h exp=%h", k, out_k(k), exp_d);
      end
    end
    in_valid_i = 1'b0;
    step();
    checks++;
    if (out_valid_o !== 4'b0000) begin
      failures++;
      $display("FAIL route_drained got=%b exp=0000", out_valid_o);
    end
  endtask

  task automatic test_backpressure();
    out_ready_i = 4'b1011;
    in_valid_i  = 1'b1;
    sel_i       = 2'd2;
    in_i        = 8'h11;
    step();
    checks++;
    if (out_valid_o !== 4'b0100 || out2_o !== 8'h11) begin
      failures++;
      $display("FAIL bp_first got=%b/%h exp=0100/11", out_valid_o, out2_o);
    end
    in_i = 8'h22;
    #1;
    checks++;
    if (in_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL bp_stall_ready got=%b exp=0", in_ready_o);
    end
    step();
    checks++;
    if (out_valid_o !== 4'b0100 || out2_o !== 8'h11) begin
      failures++;
      $display("FAIL bp_hold got=%b/%h exp=0100/11", out_valid_o, out2_o);
    end
    out_ready_i = 4'b1111;
    #1;
    checks++;
    if (in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_ready got=%b exp=1", in_ready_o);
    end
    step();
    checks++;
    if (out_valid_o !== 4'b0100 || out2_o !== 8'h22) begin
      failures++;
      $display("FAIL bp_replace got=%b/%h exp=0100/22", out_valid_o, out2_o);
    end
    in_valid_i  = 1'b0;
    out_ready_i = 4'b1011;
  endtask

  task automatic test_independence();
    // Slot 2 is stalled holding 8'h22.
    out_ready_i = 4'b1010;
    in_valid_i  = 1'b1;
    sel_i       = 2'd0;
    in_i        = 8'h44;
    step();
    checks++;
    if (out_valid_o !== 4'b0101 || out0_o !== 8'h44) begin
      failures++;
      $display("FAIL ind_load0 got=%b/%h exp=0101/44", out_valid_o, out0_o);
    end
    out_ready_i = 4'b1011;
    sel_i       = 2'd1;
    in_i        = 8'h33;
    step();
    checks++;
    if (out_valid_o !== 4'b0110 || out1_o !== 8'h33) begin
      failures++;
      $display("FAIL ind_load1 got=%b/%h exp=0110/33", out_valid_o, out1_o);
    end
    in_valid_i = 1'b0;
    step();
    checks++;
    if (out_valid_o !== 4'b0100 || out2_o !== 8'h22) begin
      failures++;
      $display("FAIL ind_slot2 got=%b/%h exp=0100/22", out_valid_o, out2_o);
    end
  endtask

  task automatic test_reset_mid();
    out_ready_i = 4'b0000;
    in_valid_i  = 1'b1;
    sel_i       = 2'd0;
    in_i        = 8'h55;
    step();
    sel_i = 2'd3;
    in_i  = 8'h66;
    step();
    checks++;
    if (out_valid_o !== 4'b1101 || out0_o !== 8'h55 || out3_o !== 8'h66) begin
      failures++;
      $display("FAIL mid_fill got=%b/%h/%h exp=1101/55/66", out_valid_o, out0_o, out3_o);
    end
    in_valid_i = 1'b0;
    rst_i      = 1'b1;
    step();
    rst_i = 1'b0;
    checks++;
    if (out_valid_o !== 4'b0000 || out0_o !== 8'h00 || out2_o !== 8'h00 || out3_o !== 8'h00)
    begin
      failures++;
      $display("FAIL mid_reset got=%b/%h/%h/%h exp=0000/00/00/00", out_valid_o, out0_o, out2_o,
               out3_o);
    end
    in_valid_i = 1'b1;
    sel_i      = 2'd3;
    in_i       = 8'h77;
    #1;
    checks++;
    if (in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_in_ready got=%b exp=1", in_ready_o);
    end
    step();
    in_valid_i = 1'b0;
    checks++;
    if (out_valid_o !== 4'b1000 || out3_o !== 8'h77) begin
      failures++;
      $display("FAIL mid_accept got=%b/%h exp=1000/77", out_valid_o, out3_o);
    end
  endtask

`ifdef DEMUX_REGISTERED_CNT_EN
  task automatic test_counters();
    // Slot 3 holds 8'h77 and drains on the first edge below.
    cnt_clr_i   = 1'b0;
    out_ready_i = 4'b1111;
    in_valid_i  = 1'b1;
    sel_i       = 2'd1;
    for (int i = 0; i < 20; i++) begin
      in_i = 8'(i);
      step();
      if (i == 9) begin
        checks++;
        if (cnt1_o !== 4'd9) begin
          failures++;
          $display("FAIL cnt_mid got=%0d exp=9", cnt1_o);
        end
      end
    end
    in_valid_i = 1'b0;
    step();
    checks++;
    if (cnt1_o !== 4'hF) begin
      failures++;
      $display("FAIL cnt_sat got=%h exp=F", cnt1_o);
    end
    checks++;
    if (cnt3_o !== 4'd1 || cnt0_o !== 4'd0) begin
      failures++;
      $display("FAIL cnt_other got=%0d/%0d exp=1/0", cnt3_o, cnt0_o);
    end
    in_valid_i = 1'b1;
    in_i       = 8'h99;
    step();
    in_valid_i = 1'b0;
    cnt_clr_i  = 1'b1;
    step();
    cnt_clr_i = 1'b0;
    checks++;
    if (cnt1_o !== 4'd0 || cnt3_o !== 4'd0 || out_valid_o !== 4'b0000) begin
      failures++;
      $display("FAIL cnt_clr got=%0d/%0d/%b exp=0/0/0000", cnt1_o, cnt3_o, out_valid_o);
    end
  endtask
`endif

  initial begin
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    sel_i       = 2'd0;
    in_i        = '0;
    out_ready_i = 4'b0000;
`ifdef DEMUX_REGISTERED_CNT_EN
    cnt_clr_i   = 1'b0;
`endif
    test_reset();
    test_routing();
    test_backpressure();
    test_independence();
    test_reset_mid();
`ifdef DEMUX_REGISTERED_CNT_EN
    test_counters();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
